// File: rtl/lfsr_prbs_gen.sv
// Multi-polynomial Fibonacci LFSR PRBS generator emitting SYM_BITS bits per symbol
// with a valid/ready handshake, seed load/restart and start-state wrap detection.
module lfsr_prbs_gen #(
  parameter int unsigned MAX_WIDTH = 31,
  parameter int unsigned SYM_BITS  = 2,
  parameter int unsigned DEF_POLY  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [2:0]           poly_sel,
  input  logic [MAX_WIDTH-1:0] seed_in,
  input  logic                 en,
  input  logic                 sym_ready,
  output logic                 sym_valid,
  output logic [SYM_BITS-1:0]  sym_out,
  output logic [MAX_WIDTH-1:0] seq_out,
  output logic                 wrap,
  output logic                 seed_fix,
  output logic                 cfg_err
);

  localparam int unsigned IDX_W    = $clog2(MAX_WIDTH);
  localparam int unsigned POLY_W   = 3;
  localparam int unsigned MAX_CODE = 5;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_t;

  // Register length N for each legal polynomial code; illegal codes fold to PRBS7.
  function automatic int unsigned poly_len(input logic [POLY_W-1:0] code);
    case (code)
      3'd1:    return 9;
      3'd2:    return 15;
      3'd3:    return 22;
      3'd4:    return 23;
      3'd5:    return 31;
      default: return 7;
    endcase
  endfunction

  // Zero-based index of the second feedback tap (b-1).
  function automatic int unsigned poly_tap_b(input logic [POLY_W-1:0] code);
    case (code)
      3'd1:    return 4;
      3'd2:    return 13;
      3'd3:    return 20;
      3'd4:    return 17;
      3'd5:    return 27;
      default: return 5;
    endcase
  endfunction

  function automatic logic [MAX_WIDTH-1:0] len_mask(input int unsigned len);
    return MAX_WIDTH'((64'd1 << len) - 64'd1);
  endfunction

  fsm_t                  fsm_q, fsm_d;
  logic [POLY_W-1:0]     poly_q, poly_d;
  logic [MAX_WIDTH-1:0]  state_q, state_d;
  logic [MAX_WIDTH-1:0]  start_q, start_d;
  logic                  sym_valid_d;
  logic [SYM_BITS-1:0]   sym_out_d;
  logic                  wrap_d;
  logic                  seed_fix_d;
  logic                  cfg_err_d;

  logic [MAX_WIDTH-1:0]  act_mask_c;
  logic [IDX_W-1:0]      tap_a_c;
  logic [IDX_W-1:0]      tap_b_c;

  logic [POLY_W-1:0]     load_code_c;
  logic [MAX_WIDTH-1:0]  load_seed_c;
  logic                  load_zero_c;

  logic [MAX_WIDTH-1:0]  lfsr_s;
  logic [SYM_BITS-1:0]   lfsr_sym;
  logic                  lfsr_f;
  logic [MAX_WIDTH-1:0]  step_state_c;
  logic [SYM_BITS-1:0]   step_sym_c;
  logic                  advance_c;

  // Active taps and length mask from the latched polynomial.
  always_comb begin
    act_mask_c = len_mask(poly_len(poly_q));
    tap_a_c    = IDX_W'(poly_len(poly_q) - 1);
    tap_b_c    = IDX_W'(poly_tap_b(poly_q));
  end

  // Seed conditioning for a load: fold illegal codes, mask to N bits, replace zero.
  always_comb begin
    load_code_c = (32'(poly_sel) > MAX_CODE) ? POLY_W'(0) : poly_sel;
    load_seed_c = seed_in & len_mask(poly_len(load_code_c));
    load_zero_c = (load_seed_c == '0);
    if (load_zero_c) begin
      load_seed_c = MAX_WIDTH'(1);
    end
  end

  // SYM_BITS serial steps unrolled into one edge; first feedback bit lands in the MSB.
  always_comb begin
    lfsr_s   = state_q;
    lfsr_sym = '0;
    lfsr_f   = 1'b0;
    for (int k = 0; k < int'(SYM_BITS); k++) begin
      lfsr_f   = lfsr_s[tap_a_c] ^ lfsr_s[tap_b_c];
      lfsr_s   = {lfsr_s[MAX_WIDTH-2:0], lfsr_f} & act_mask_c;
      lfsr_sym = SYM_BITS'({lfsr_sym, lfsr_f});
    end
    step_state_c = lfsr_s;
    step_sym_c   = lfsr_sym;
  end

  assign advance_c = (fsm_q == RUN) && en && (!sym_valid || sym_ready) && !load;

  // Next-state and output logic.
  always_comb begin
    fsm_d       = fsm_q;
    poly_d      = poly_q;
    state_d     = state_q;
    start_d     = start_q;
    sym_valid_d = sym_valid;
    sym_out_d   = sym_out;
    wrap_d      = 1'b0;
    seed_fix_d  = 1'b0;
    cfg_err_d   = cfg_err;

    if (load) begin
      fsm_d       = RUN;
      poly_d      = load_code_c;
      state_d     = load_seed_c;
      start_d     = load_seed_c;
      sym_valid_d = 1'b0;
      seed_fix_d  = load_zero_c;
      cfg_err_d   = cfg_err || (32'(poly_sel) > MAX_CODE);
    end else begin
      case (fsm_q)
        IDLE: begin
          sym_valid_d = 1'b0;
        end
        RUN: begin
          if (advance_c) begin
            state_d     = step_state_c;
            sym_out_d   = step_sym_c;
            sym_valid_d = 1'b1;
            wrap_d      = (step_state_c == start_q);
          end else if (sym_valid && sym_ready && !en) begin
            sym_valid_d = 1'b0;
          end
        end
        default: begin
          fsm_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q     <= IDLE;
      poly_q    <= POLY_W'(DEF_POLY);
      state_q   <= MAX_WIDTH'(1);
      start_q   <= MAX_WIDTH'(1);
      sym_valid <= 1'b0;
      sym_out   <= '0;
      wrap      <= 1'b0;
      seed_fix  <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      poly_q    <= poly_d;
      state_q   <= state_d;
      start_q   <= start_d;
      sym_valid <= sym_valid_d;
      sym_out   <= sym_out_d;
      wrap      <= wrap_d;
      seed_fix  <= seed_fix_d;
      cfg_err   <= cfg_err_d;
    end
  end

  assign seq_out = state_q;

endmodule
